// File: rtl/priority_resolver.sv
// Priority resolution stage of an 8259A-compatible interrupt controller.
// Picks the highest-priority pending request under a rotating priority base,
// blocks it when an equal-or-higher-priority interrupt is already in service,
// and raises a single INT_request per distinct winner with a toggle-acknowledge
// handshake towards the control/INTA sequencer.
module priority_resolver #(
   parameter int NUM_IR = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              freezing,
   input  logic [NUM_IR-1:0] IRR_reg,
   input  logic [NUM_IR-1:0] ISR_reg,
   input  logic [2:0]        resetedISR_index,
   input  logic [7:0]        OCW2,
   input  logic              INT_requestAck,
   output logic [2:0]        serviced_interrupt_index,
   output logic [2:0]        zeroLevelPriorityBit,
   output logic              INT_request
);

   // Rank (0 = highest) of the first set bit scanning circularly from base;
   // returns 8 when no bit is set. Descending scan so the lowest offset wins.
   function automatic logic [3:0] lowest_rank(input logic [NUM_IR-1:0] vec,
                                              input logic [2:0]        base);
      logic [3:0] rank_v;
      logic [2:0] pos_v;
      rank_v = 4'd8;
      for (int off = NUM_IR - 1; off >= 0; off--) begin
         pos_v = base + 3'(off);
         if (vec[pos_v]) begin
            rank_v = 4'(off);
         end else begin
            rank_v = rank_v;
         end
      end
      return rank_v;
   endfunction

   logic [2:0] zlp_r;
   logic [2:0] index_r;
   logic       req_r;
   logic       armed_r;
   logic       ack_sample_r;

   logic [3:0] winner_rank_s;
   logic [3:0] isr_top_s;
   logic [2:0] winner_s;
   logic       serviceable_s;
   logic [2:0] zlp_next_s;
   logic [2:0] index_next_s;
   logic       req_next_s;
   logic       armed_next_s;
   logic       sample_next_s;
   logic       ack_seen_s;
   logic       rise_s;
   logic       rearm_s;
   logic       unused_ocw2_s;

   // OCW2[4:3] carry no meaning for priority resolution.
   assign unused_ocw2_s = ^OCW2[4:3];

   // Resolve winner and in-service ceiling against the current (pre-update) base.
   always_comb begin
      winner_rank_s = lowest_rank(IRR_reg, zlp_r);
      isr_top_s     = lowest_rank(ISR_reg, zlp_r);
      winner_s      = zlp_r + winner_rank_s[2:0];
      serviceable_s = (IRR_reg != {NUM_IR{1'b0}}) && (winner_rank_s < isr_top_s);
   end

   // Decode the OCW2 rotation command into the next priority base.
   always_comb begin
      zlp_next_s = zlp_r;
      case (OCW2[7:5])
         3'b000, 3'b100, 3'b101: zlp_next_s = resetedISR_index + 3'd1;
         3'b110, 3'b111:         zlp_next_s = OCW2[2:0] + 3'd1;
         3'b001, 3'b011:         zlp_next_s = 3'd0;
         default:                zlp_next_s = zlp_r;
      endcase
   end

   // Request/acknowledge handshake and winner capture; a rise defers any
   // coincident ack to the following clock by keeping the old sample.
   always_comb begin
      ack_seen_s    = INT_requestAck ^ ack_sample_r;
      rise_s        = serviceable_s & armed_r & ~freezing;
      rearm_s       = ~serviceable_s | (winner_s != index_r);
      index_next_s  = index_r;
      req_next_s    = req_r;
      armed_next_s  = armed_r;
      sample_next_s = ack_sample_r;
      if (!freezing && serviceable_s) begin
         index_next_s = winner_s;
      end else begin
         index_next_s = index_r;
      end
      if (rise_s) begin
         req_next_s    = 1'b1;
         armed_next_s  = 1'b0;
         sample_next_s = ack_sample_r;
      end else if (req_r) begin
         armed_next_s = armed_r | rearm_s;
         if (ack_seen_s && !freezing) begin
            req_next_s    = 1'b0;
            sample_next_s = INT_requestAck;
         end else begin
            req_next_s    = 1'b1;
            sample_next_s = ack_sample_r;
         end
      end else begin
         req_next_s    = 1'b0;
         armed_next_s  = armed_r | rearm_s;
         sample_next_s = INT_requestAck;
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         zlp_r        <= 3'd0;
         index_r      <= 3'd0;
         req_r        <= 1'b0;
         armed_r      <= 1'b1;
         ack_sample_r <= 1'b0;
      end else begin
         zlp_r        <= zlp_next_s;
         index_r      <= index_next_s;
         req_r        <= req_next_s;
         armed_r      <= armed_next_s;
         ack_sample_r <= sample_next_s;
      end
   end

   assign zeroLevelPriorityBit     = zlp_r;
   assign serviced_interrupt_index = index_r;
   assign INT_request              = req_r;

endmodule

// File: tb/tb_priority_resolver.sv
// Self-checking bench for priority_resolver: directed steps from the test plan
// followed by random stimulus, all checked against a cycle-level reference model.
module tb_priority_resolver;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       freezing;
   logic [7:0] irr;
   logic [7:0] isr;
   logic [2:0] rst_idx;
   logic [7:0] ocw2;
   logic       ack;
   logic [2:0] idx;
   logic [2:0] zlp;
   logic       int_req;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   int m_zlp, m_idx, m_req, m_armed, m_sample;

   priority_resolver #(.NUM_IR(8)) dut (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .freezing                 (freezing),
      .IRR_reg                  (irr),
      .ISR_reg                  (isr),
      .resetedISR_index         (rst_idx),
      .OCW2                     (ocw2),
      .INT_requestAck           (ack),
      .serviced_interrupt_index (idx),
      .zeroLevelPriorityBit     (zlp),
      .INT_request              (int_req)
   );

   // free-running clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_zlp = 0; m_idx = 0; m_req = 0; m_armed = 1; m_sample = 0;
   endtask

   // One clock of the reference model, written from the behavioural rules:
   // rank(n) = (n - base) mod 8, lowest rank wins, equal-rank ISR blocks.
   task automatic model_clock();
      int  win, wrank, itop, r, n_zlp, n_idx, n_req, n_armed, n_sample;
      bit  serv, rise, ackd;
      win = 0; wrank = 8; itop = 8;
      for (int n = 0; n < 8; n++) begin
         r = (n - m_zlp + 8) % 8;
         if (irr[n] && r < wrank) begin wrank = r; win = n; end
         if (isr[n] && r < itop) itop = r;
      end
      serv = (irr != 8'd0) && (wrank < itop);
      ackd = (int'(ack) != m_sample);
      rise = serv && (m_armed == 1) && !freezing;
      n_idx = (!freezing && serv) ? win : m_idx;
      if (rise) begin
         n_req = 1; n_armed = 0; n_sample = m_sample;
      end else begin
         n_armed = (m_armed == 1 || !serv || win != m_idx) ? 1 : 0;
         if (m_req == 1) begin
            if (ackd && !freezing) begin n_req = 0; n_sample = int'(ack); end
            else begin n_req = 1; n_sample = m_sample; end
         end else begin
            n_req = 0; n_sample = int'(ack);
         end
      end
      case (ocw2[7:5])
         3'd0, 3'd4, 3'd5: n_zlp = (int'(rst_idx) + 1) % 8;
         3'd6, 3'd7:       n_zlp = (int'(ocw2[2:0]) + 1) % 8;
         3'd1, 3'd3:       n_zlp = 0;
         default:          n_zlp = m_zlp;
      endcase
      m_zlp = n_zlp; m_idx = n_idx; m_req = n_req; m_armed = n_armed; m_sample = n_sample;
   endtask

   // advance one clock, update the model, then compare all outputs
   task automatic step(input string tag);
      @(posedge clk);
      model_clock();
      #1;
      check({tag, ".idx"}, 8'(idx), 8'(m_idx));
      check({tag, ".zlp"}, 8'(zlp), 8'(m_zlp));
      check({tag, ".req"}, 8'(int_req), 8'(m_req));
   endtask

   initial begin
      reset_n = 1'b0; freezing = 1'b0; irr = 8'hFF; isr = 8'h00;
      rst_idx = 3'd0; ocw2 = 8'h20; ack = 1'b0;
      model_reset();
      #12;
      check("reset.idx", 8'(idx), 8'd0);
      check("reset.zlp", 8'(zlp), 8'd0);
      check("reset.req", 8'(int_req), 8'd0);
      #2 reset_n = 1'b1;
      step("first");
      check("first.idx_c", 8'(idx), 8'd0);
      check("first.req_c", 8'(int_req), 8'd1);

      // automatic rotation
      irr = 8'h00; ocw2 = 8'hA0; rst_idx = 3'd3;
      step("auto");
      check("auto.zlp_c", 8'(zlp), 8'd4);
      irr = 8'h21;
      step("auto_win");
      check("auto_win.idx_c", 8'(idx), 8'd5);
      rst_idx = 3'd7;
      step("wrap");
      check("wrap.zlp_c", 8'(zlp), 8'd0);

      // specific rotation and no-op
      ocw2 = 8'hC2;
      step("spec");
      check("spec.zlp_c", 8'(zlp), 8'd3);
      ocw2 = 8'h47;
      step("noop");
      check("noop.zlp_c", 8'(zlp), 8'd3);

      // fixed priority, clear any outstanding request
      ocw2 = 8'h20; irr = 8'h00; ack = ~ack;
      step("fix0"); step("fix1");
      check("fix.req_c", 8'(int_req), 8'd0);

      // ISR blocking
      isr = 8'h04; irr = 8'h08;
      step("blk0"); step("blk1");
      check("blk.req_c", 8'(int_req), 8'd0);
      irr = 8'h0A;
      step("pass");
      check("pass.idx_c", 8'(idx), 8'd1);
      check("pass.req_c", 8'(int_req), 8'd1);
      isr = 8'h02; irr = 8'h02; ack = ~ack;
      step("eq0"); step("eq1");
      check("eq.req_c", 8'(int_req), 8'd0);

      // handshake
      isr = 8'h00; irr = 8'h10;
      step("hs_rise");
      check("hs_rise.idx_c", 8'(idx), 8'd4);
      check("hs_rise.req_c", 8'(int_req), 8'd1);
      ack = ~ack;
      step("hs_ack");
      check("hs_ack.req_c", 8'(int_req), 8'd0);
      for (int i = 0; i < 3; i++) begin
         step("hs_hold");
         check("hs_hold.req_c", 8'(int_req), 8'd0);
      end
      irr = 8'h18;
      step("hs_new0"); step("hs_new1");
      check("hs_new.idx_c", 8'(idx), 8'd3);
      check("hs_new.req_c", 8'(int_req), 8'd1);
      ack = ~ack;
      step("hs_ack2");
      check("hs_ack2.req_c", 8'(int_req), 8'd0);

      // freezing
      irr = 8'h10;
      step("fz_pre0"); step("fz_pre1");
      ack = ~ack;
      step("fz_pre2");
      check("fz_pre.idx_c", 8'(idx), 8'd4);
      freezing = 1'b1; irr = 8'h01;
      step("fz0"); step("fz1");
      check("fz.idx_c", 8'(idx), 8'd4);
      check("fz.req_c", 8'(int_req), 8'd0);
      freezing = 1'b0;
      step("unfz");
      check("unfz.idx_c", 8'(idx), 8'd0);
      check("unfz.req_c", 8'(int_req), 8'd1);

      // reset mid-handshake, then first request needs no ack
      reset_n = 1'b0;
      #1;
      model_reset();
      check("midrst.idx", 8'(idx), 8'd0);
      check("midrst.req", 8'(int_req), 8'd0);
      reset_n = 1'b1;
      irr = 8'h04;
      step("post_rst");
      check("post_rst.req_c", 8'(int_req), 8'd1);
      check("post_rst.idx_c", 8'(idx), 8'd2);

      // randomized stimulus against the model
      for (int i = 0; i < 400; i++) begin
         irr      = 8'($urandom) & 8'($urandom);
         isr      = 8'($urandom) & 8'($urandom) & 8'($urandom);
         ocw2     = 8'($urandom);
         rst_idx  = 3'($urandom);
         freezing = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) ack = ~ack;
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/priority_resolver.md
Name: priority_resolver

Overview:
- Priority resolution stage of the 8259A-compatible PIC.
- Takes the IRR and ISR images plus OCW2 rotation commands, and picks the highest-priority pending request that may interrupt current service.
- Tracks the rotating priority base, raises INT_request towards the control logic, and completes a toggle-acknowledge handshake.
- Sits between the IRR/ISR registers and the control/INTA sequencer.

Parameters:
- NUM_IR, 8, number of interrupt lines (fixed at 8; index width 3).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- freezing  input  1  1 = hold resolver outputs (INTA sequence in progress)
- IRR_reg  input  8  pending requests, bit n = IRn
- ISR_reg  input  8  in-service bits, bit n = IRn
- resetedISR_index  input  3  index of the ISR bit most recently cleared by EOI
- OCW2  input  8  OCW2 command image; [7:5]=R,SL,EOI; [2:0]=L2..L0
- INT_requestAck  input  1  toggle acknowledge; any change of level acknowledges
- serviced_interrupt_index  output  3  index of the winning request
- zeroLevelPriorityBit  output  3  IR index currently holding highest priority (priority level 0)
- INT_request  output  1  interrupt request towards the control logic

Behaviour:
Reset:
- reset_n low, asynchronously: zeroLevelPriorityBit=0, serviced_interrupt_index=0, INT_request=0, internal ack-sample register=0, armed flag=1.

Priority base update (every clock, regardless of freezing), decoded from OCW2[7:5]:
- 000, 100, 101 (automatic rotation): zeroLevelPriorityBit <= resetedISR_index+1, modulo 8 (7 wraps to 0).
- 110, 111 (specific rotation / set priority): zeroLevelPriorityBit <= OCW2[2:0]+1, modulo 8.
- 001, 011 (non-rotating EOI): zeroLevelPriorityBit <= 0 (fixed priority, IR0 highest).
- 010: hold.

Priority rank:
- rank(n) = (n − zeroLevelPriorityBit) mod 8; rank 0 is the highest priority.
- Rank uses the current registered zeroLevelPriorityBit.

Resolution (combinational):
- winner = the IRR bit with the lowest rank. Scan circularly starting at zeroLevelPriorityBit.
- isrTop = lowest rank among the set ISR bits; 8 if ISR is empty.
- serviceable = (IRR ≠ 0) and rank(winner) < isrTop. An equal-rank ISR bit blocks the request.

Registered outputs (1-clock latency from input change):
- freezing=1: serviced_interrupt_index and INT_request hold; ack detection still operates.
- freezing=0 and serviceable: serviced_interrupt_index <= winner.
- Otherwise serviced_interrupt_index holds its last value.

Handshake:
- INT_request rises one clock after serviceable is true, armed=1, and freezing=0. Rising clears armed.
- INT_request stays high until ack is detected: INT_requestAck differs from its sampled value. It then drops on the next clock, and the sample is updated.
- armed sets again when serviceable goes false, or when the winner index changes.
- Result: exactly one request per distinct winner; no re-request while the same winner remains pending.
- Ack arriving when INT_request=0: sample updates, no other effect.
- Ack in the same cycle as a new rise: the rise wins, and the ack is consumed on the next clock.
- Simultaneous rotation update and resolution: resolution uses the pre-update zeroLevelPriorityBit. The new base takes effect next cycle.
- Reset mid-handshake: everything returns to reset values immediately; the first request after reset needs no prior ack.

Size: ~150–250 lines of RTL (rotate, priority encode, compare, handshake FSM IDLE/REQ/WAIT_REARM).

Test Plan:
- Reset: reset_n=0 with IRR=FF → all outputs 0 immediately. Release, OCW2=0x20 (EOI, fixed priority), ISR=00 → next clock serviced_interrupt_index=0, INT_request=1.
- Auto rotation: OCW2=0xA0, resetedISR_index=3 → zeroLevelPriorityBit=4 after one clock. Then IRR=0x21 → winner 5, because rank(5)=1 < rank(0)=4. resetedISR_index=7 → zeroLevelPriorityBit wraps to 0.
- Specific rotation: OCW2=0xC2 → zeroLevelPriorityBit=3. OCW2=0x47 (no-op) → stays 3.
- ISR blocking, fixed priority: ISR=0x04, IRR=0x08 → INT_request stays 0. IRR=0x0A → winner 1, INT_request=1. ISR=0x02 with IRR=0x02 → blocked (equal rank).
- Handshake: IRR=0x10, ISR=0 → INT_request=1. Toggle INT_requestAck → INT_request=0 next clock, no re-assert while IRR stays 0x10. IRR=0x18 → winner changes to 3, new pulse. Toggle ack again → INT_request drops.
- Freezing: with serviced_interrupt_index=4, freezing=1, IRR changes to 0x01 → index stays 4, no new INT_request. freezing=0 → index 0, INT_request=1.
